// File: rtl/imem_dmem_bus_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory bus arbiter.
package imem_dmem_bus_arbiter_pkg;

  // Bus ownership state: idle, fetch transaction, data transaction.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StIbus = 2'b01,
    StDbus = 2'b10
  } arb_state_e;

  // Width of the data-streak counter (MAX_DSTREAK is at most 15).
  localparam int unsigned StreakW = 4;
  // Width of the wait timer (TIMEOUT is at most 255).
  localparam int unsigned TimerW  = 8;

  // Saturating increment for the data-streak counter.
  function automatic logic [StreakW-1:0] streak_inc(input logic [StreakW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/imem_dmem_bus_arbiter_wait_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module imem_dmem_bus_arbiter_wait_timer #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RESN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q;

  // Count register: load takes priority, then count down to zero and hold.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/imem_dmem_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the load/store unit.
// One transaction outstanding at a time; data wins unless fetch has waited through
// MAX_DSTREAK consecutive data grants. A flush discards an in-flight fetch result.
module imem_dmem_bus_arbiter
  import imem_dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                CLK,
  input  logic                RESN,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                flush,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  // memory bus
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  // status
  output logic                HLT,
  output logic                bus_err
);

  localparam int unsigned         BeW         = DATA_W / 8;
  localparam logic [StreakW-1:0]  MaxStreak   = StreakW'(MAX_DSTREAK);
  // Loaded at grant so the timer reaches zero in the TIMEOUT-th cycle of mem_req.
  localparam logic [TimerW-1:0]   TimeoutLoad = TimerW'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [StreakW-1:0]  dstreak_q;
  logic                drop_q;
  logic                mem_req_q, mem_we_q;
  logic [BeW-1:0]      mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                i_ack_q, d_ack_q, bus_err_q;
  logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

  logic                idle_ok, grant_d, grant_i, bus_active;
  logic                timer_expired, timeout, finish, drop_now;
  logic [DATA_W-1:0]   fin_rdata;

  // Grants only from a true idle cycle: never in the cycle an ack is being shown.
  assign idle_ok    = (state_q == StIdle) && !i_ack_q && !d_ack_q;
  assign grant_d    = idle_ok && d_req && ((dstreak_q < MaxStreak) || !i_req);
  assign grant_i    = idle_ok && !grant_d && i_req && !flush;
  assign bus_active = (state_q != StIdle);
  assign timeout    = bus_active && !mem_ready && timer_expired;
  assign finish     = (bus_active && mem_ready) || timeout;
  // A flush arriving together with completion still discards the fetch.
  assign drop_now   = drop_q || ((state_q == StIbus) && flush);
  assign fin_rdata  = mem_ready ? mem_rdata : '0;

  imem_dmem_bus_arbiter_wait_timer #(
    .W (TimerW)
  ) u_wait_timer (
    .CLK      (CLK),
    .RESN     (RESN),
    .load     (grant_d || grant_i),
    .load_val (TimeoutLoad),
    .en       (bus_active),
    .expired  (timer_expired)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: idle grants a bus owner, a bus state ends on ready or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d = StDbus;
        end else if (grant_i) begin
          state_d = StIbus;
        end
      end
      StIbus, StDbus: begin
        if (finish) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bus command, completion handshake, streak counter and sticky error.
  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      dstreak_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_be_q    <= d_be;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        if (i_req) begin
          dstreak_q <= streak_inc(dstreak_q);
        end
      end else if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_be_q    <= '1;
        mem_addr_q  <= i_addr;
        mem_wdata_q <= '0;
        dstreak_q   <= '0;
      end else if (finish) begin
        mem_req_q <= 1'b0;
        drop_q    <= 1'b0;
        if (timeout) begin
          bus_err_q <= 1'b1;
        end
        if (state_q == StDbus) begin
          d_ack_q   <= 1'b1;
          d_rdata_q <= fin_rdata;
        end else if (!drop_now) begin
          i_ack_q   <= 1'b1;
          i_rdata_q <= fin_rdata;
        end
      end else if ((state_q == StIbus) && flush) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign bus_err   = bus_err_q;
  assign HLT       = (i_req && !i_ack_q) || (d_req && !d_ack_q);

endmodule

// File: tb/tb_imem_dmem_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_imem_dmem_bus_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXS = 4;
  localparam int unsigned TO   = 64;

  logic            CLK, RESN;
  logic            i_req, i_ack, flush, d_req, d_we, d_ack;
  logic [AW-1:0]   i_addr, d_addr, mem_addr;
  logic [DW-1:0]   i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [DW/8-1:0] d_be, mem_be;
  logic            mem_req, mem_we, mem_ready, HLT, bus_err;

  imem_dmem_bus_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_DSTREAK (MAXS),
    .TIMEOUT     (TO)
  ) dut (
    .CLK       (CLK),
    .RESN      (RESN),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .flush     (flush),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .HLT       (HLT),
    .bus_err   (bus_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), the command it issued,
  // how many bus cycles it has already waited, and what the requesters should see.
  int              m_owner, m_waited, m_streak;
  bit              m_drop, m_iack, m_dack, m_err;
  logic            m_we;
  logic [3:0]      m_be;
  logic [31:0]     m_addr, m_wdata, m_irdata, m_drdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_waited = 0; m_streak = 0; m_drop = 0;
    m_iack = 0; m_dack = 0; m_err = 0;
    m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit          ni, nd, dropn, to;
    logic [31:0] v;
    ni = 0; nd = 0;
    if (m_owner != 0) begin
      dropn = m_drop || (m_owner == 1 && flush);
      to    = !mem_ready && (m_waited + 1 >= int'(TO));
      if (mem_ready || to) begin
        v = mem_ready ? mem_rdata : 32'h0;
        if (to) m_err = 1;
        if (m_owner == 2) begin
          nd = 1; m_drdata = v;
        end else if (!dropn) begin
          ni = 1; m_irdata = v;
        end
        m_owner = 0; m_drop = 0;
      end else begin
        m_waited++;
        m_drop = dropn;
      end
    end else if (!m_iack && !m_dack) begin
      if (d_req && (m_streak < int'(MAXS) || !i_req)) begin
        m_owner = 2; m_waited = 0;
        m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
        if (i_req && m_streak < 15) m_streak++;
      end else if (i_req && !flush) begin
        m_owner = 1; m_waited = 0; m_we = 0; m_addr = i_addr;
        m_streak = 0;
      end
    end
    m_iack = ni; m_dack = nd;
  endtask

  task automatic compare_outputs();
    chk("mem_req", mem_req, m_owner != 0);
    if (m_owner != 0) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_owner == 2) begin
        chk("mem_be", mem_be, m_be);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
    chk("i_ack", i_ack, m_iack);
    chk("d_ack", d_ack, m_dack);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    chk("bus_err", bus_err, m_err);
  endtask

  // Called at a falling edge right after inputs are driven; returns at the next one.
  task automatic tick();
    #1;
    chk("HLT", HLT, (i_req && !m_iack) || (d_req && !m_dack));
    model_step();
    @(negedge CLK);
    compare_outputs();
  endtask

  initial begin
    logic [5:0] seq;
    int         cnt;
    int         mode;
    RESN = 0; i_req = 0; i_addr = 0; flush = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    RESN = 1;
    compare_outputs();

    // 1: lone fetch, ready two cycles after mem_req rises
    i_req = 1; i_addr = 32'h40;
    tick();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    tick(); tick();
    mem_ready = 1; mem_rdata = 32'h0000_0013;
    tick();
    chk("t1_i_ack", i_ack, 1);
    chk("t1_i_rdata", i_rdata, 32'h13);
    chk("t1_hlt_low", HLT, 0);
    i_req = 0; mem_ready = 0;
    tick();

    // 2: simultaneous requests, data store goes first
    i_req = 1; i_addr = 32'h44;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hCAFE;
    tick();
    chk("t2_d_first_we", mem_we, 1);
    chk("t2_d_addr", mem_addr, 32'h100);
    chk("t2_d_be", mem_be, 4'b0011);
    mem_ready = 1; mem_rdata = 32'hA5A5_0000;
    tick();
    chk("t2_d_ack", {d_ack, i_ack}, 2'b10);
    d_req = 0; mem_ready = 0;
    tick();
    chk("t2_no_regrant", mem_req, 0);
    tick();
    chk("t2_i_grant", {mem_req, mem_we}, 2'b10);
    chk("t2_i_addr", mem_addr, 32'h44);
    mem_ready = 1; mem_rdata = 32'h77;
    tick();
    chk("t2_i_ack", i_ack, 1);
    i_req = 0; mem_ready = 0;
    tick();

    // 3: data streak with fetch waiting; 5th grant must be the fetch
    i_req = 1; i_addr = 32'h48;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h104; d_wdata = 32'h1234;
    mem_rdata = 32'h55;
    seq = '0;
    for (int g = 0; g < 6; g++) begin
      mem_ready = 0;
      tick();
      if (!mem_req) tick();
      seq[g] = mem_we;
      mem_ready = 1;
      tick();
      if (g == 5) begin i_req = 0; d_req = 0; end
    end
    chk("t3_grant_seq", seq, 6'b101111);
    mem_ready = 0;
    tick();

    // 4: flush in the 2nd IBUS cycle, ready in the 4th
    i_req = 1; i_addr = 32'h80;
    tick();
    chk("t4_ibus", {mem_req, mem_we}, 2'b10);
    tick();
    flush = 1;
    tick();
    flush = 0; i_addr = 32'h200;
    tick();
    mem_ready = 1; mem_rdata = 32'hDEAD;
    tick();
    chk("t4_no_ack", {mem_req, i_ack}, 0);
    chk("t4_rdata_kept", i_rdata, 32'h55);
    i_req = 0; mem_ready = 0;
    tick();
    chk("t4_idle", mem_req, 0);

    // 5: timeout on a load
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    cnt = 0;
    while (mem_req && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("t5_req_cycles", cnt, TO);
    chk("t5_ack_zero", {d_ack, d_rdata}, {1'b1, 32'h0});
    chk("t5_bus_err", bus_err, 1);
    d_req = 0;
    tick();
    tick();
    chk("t5_err_sticky", bus_err, 1);

    // 6: reset in the middle of a data transaction
    d_req = 1; d_we = 1; d_addr = 32'h300;
    tick();
    chk("t6_dbus", mem_req, 1);
    #2 RESN = 0;
    #1;
    chk("t6_rst_req", mem_req, 0);
    chk("t6_rst_outs", {i_ack, d_ack, bus_err, i_rdata, d_rdata}, 0);
    model_reset();
    d_req = 0;
    @(negedge CLK);
    RESN = 1;
    compare_outputs();

    // Randomized traffic; every 200 cycles change the memory responsiveness
    for (int c = 0; c < 4000; c++) begin
      mode = (c / 200) % 4;
      if (!i_req || m_iack) begin
        i_req  = ($urandom_range(0, 2) == 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || m_dack) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = $urandom_range(0, 1) != 0;
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      flush = ($urandom_range(0, 7) == 0);
      if (flush && i_req && !m_iack) i_addr = $urandom & 32'hFFFF_FFFC;
      case (mode)
        0:       mem_ready = ($urandom_range(0, 2) == 0);
        1:       mem_ready = ($urandom_range(0, 1) == 0);
        2:       mem_ready = 0;
        default: mem_ready = ($urandom_range(0, 11) == 0);
      endcase
      mem_rdata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
